// File: rtl/player_turn_fsm_pkg.sv
// Shared game types: player command encoding, turn FSM states and card constants.
package player_turn_fsm_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    HIT   = 2'd1,
    STAND = 2'd2
  } gameCommand;

  // State names carry an S_ prefix so they do not collide with the command literals.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DEAL     = 3'd1,
    S_WAIT_CMD = 3'd2,
    S_HIT      = 3'd3,
    S_DONE     = 3'd4
  } turn_state_t;

  localparam int ACE_BONUS  = 10;
  localparam int FACE_VALUE = 10;

endpackage

// File: rtl/player_turn_fsm_if.sv
// Turn-level signal bundle: controller start, player keys, deck handshake and result outputs.
interface player_turn_fsm_if;
  import player_turn_fsm_pkg::*;

  logic       start_turn;
  logic       ready;
  gameCommand command;
  logic       card_valid;
  logic [3:0] card_value;
  logic       card_req;
  logic       turnIndicator;
  logic [4:0] hand_total;
  logic       soft_hand;
  logic       busted;
  logic       blackjack;
  logic       turn_done;

  // slave = the turn FSM, master = the surrounding game logic
  modport slave (
    input  start_turn, ready, command, card_valid, card_value,
    output card_req, turnIndicator, hand_total, soft_hand, busted, blackjack, turn_done
  );

  modport master (
    output start_turn, ready, command, card_valid, card_value,
    input  card_req, turnIndicator, hand_total, soft_hand, busted, blackjack, turn_done
  );

endinterface

// File: rtl/player_turn_fsm_hand_value.sv
// Best blackjack hand value from the hard sum: one ace upgrades to 11 if that stays within TARGET.
module hand_value
  import player_turn_fsm_pkg::*;
#(
  parameter int TARGET = 21
) (
  input  logic [4:0] hard_sum,
  input  logic       ace_seen,
  output logic [4:0] hand_total,
  output logic       soft_hand
);

  assign soft_hand  = ace_seen && (hard_sum <= 5'(TARGET - ACE_BONUS));
  assign hand_total = soft_hand ? hard_sum + 5'(ACE_BONUS) : hard_sum;

endmodule

// File: rtl/player_turn_fsm.sv
// One player turn: deal DEAL_CARDS cards, then serve HIT/STAND until stand, bust or TARGET.
module player_turn_fsm
  import player_turn_fsm_pkg::*;
#(
  parameter int DEAL_CARDS = 2,
  parameter int TARGET     = 21
) (
  input  logic              clk,
  input  logic              reset_n,
  player_turn_fsm_if.slave  io
);

  turn_state_t state;
  logic [4:0]  hard_sum;
  logic        ace_seen;
  logic [3:0]  card_count;
  logic        card_req;
  logic        turn_ind;
  logic        busted;
  logic        blackjack;
  logic        turn_done;
  logic        ready_q;

  logic [4:0]  hand_total;
  logic        soft_hand;
  logic [3:0]  cval;
  logic        take;
  logic        key_edge;

  hand_value #(.TARGET(TARGET)) u_hand (
    .hard_sum  (hard_sum),
    .ace_seen  (ace_seen),
    .hand_total(hand_total),
    .soft_hand (soft_hand)
  );

  // A zero rank is not a card: the request stays up until a real one arrives.
  assign take     = card_req && io.card_valid && (io.card_value != 4'd0);
  assign cval     = (io.card_value > 4'd10) ? 4'(FACE_VALUE) : io.card_value;
  assign key_edge = io.ready && !ready_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      hard_sum   <= '0;
      ace_seen   <= 1'b0;
      card_count <= '0;
      card_req   <= 1'b0;
      turn_ind   <= 1'b0;
      busted     <= 1'b0;
      blackjack  <= 1'b0;
      turn_done  <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      ready_q   <= io.ready;
      turn_done <= 1'b0;

      if (take) begin
        hard_sum <= hard_sum + {1'b0, cval};
        ace_seen <= ace_seen | (cval == 4'd1);
        if (card_count != 4'hF) card_count <= card_count + 4'd1;
        card_req <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (io.start_turn) begin
            hard_sum   <= '0;
            ace_seen   <= 1'b0;
            card_count <= '0;
            busted     <= 1'b0;
            blackjack  <= 1'b0;
            card_req   <= 1'b1;
            state      <= S_DEAL;
          end
        end

        // Evaluation happens in the cycle after each capture, once the sum registers settle.
        S_DEAL: begin
          if (!card_req) begin
            if (card_count >= 4'(DEAL_CARDS)) begin
              if (hand_total == 5'(TARGET)) begin
                blackjack <= 1'b1;
                turn_done <= 1'b1;
                state     <= S_DONE;
              end else begin
                turn_ind <= 1'b1;
                state    <= S_WAIT_CMD;
              end
            end else begin
              card_req <= 1'b1;
            end
          end
        end

        S_WAIT_CMD: begin
          if (key_edge && io.command == HIT) begin
            turn_ind <= 1'b0;
            card_req <= 1'b1;
            state    <= S_HIT;
          end else if (key_edge && io.command == STAND) begin
            turn_ind  <= 1'b0;
            turn_done <= 1'b1;
            state     <= S_DONE;
          end
        end

        S_HIT: begin
          if (!card_req) begin
            if (hard_sum > 5'(TARGET)) begin
              busted    <= 1'b1;
              turn_done <= 1'b1;
              state     <= S_DONE;
            end else if (hand_total == 5'(TARGET)) begin
              turn_done <= 1'b1;
              state     <= S_DONE;
            end else begin
              turn_ind <= 1'b1;
              state    <= S_WAIT_CMD;
            end
          end
        end

        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign io.card_req      = card_req;
  assign io.turnIndicator = turn_ind;
  assign io.hand_total    = hand_total;
  assign io.soft_hand     = soft_hand;
  assign io.busted        = busted;
  assign io.blackjack     = blackjack;
  assign io.turn_done     = turn_done;

endmodule

// File: tb/tb_player_turn_fsm.sv
// Directed bench for player_turn_fsm: table of whole turns plus hand-written handshake/reset sequences.
module tb_player_turn_fsm;
  import player_turn_fsm_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  player_turn_fsm_if dut_if();

  player_turn_fsm #(.DEAL_CARDS(2), .TARGET(21)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .io     (dut_if.slave)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit ti_seen = 1'b0;

  always @(negedge clk) begin
    if (dut_if.turn_done === 1'b1) done_cnt++;
    if (dut_if.turnIndicator === 1'b1) ti_seen = 1'b1;
  end

  typedef struct {
    int d0, d1, h0, h1;
    bit stand;
    int deal_total;
    bit deal_soft;
    int exp_total;
    bit exp_soft, exp_bust, exp_bj, exp_ti;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // which: 0 = card_req, 1 = turnIndicator
  task automatic wait_for(input string name, input int which);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((which == 0 && dut_if.card_req === 1'b1) ||
          (which == 1 && dut_if.turnIndicator === 1'b1)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting, got 0 expected 1", name);
    end
  endtask

  task automatic wait_done(input string name, input int base);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_cnt != base) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for turn_done, got 0 expected 1", name);
    end
  endtask

  task automatic give_card(input int v);
    wait_for("card_req", 0);
    dut_if.card_valid = 1'b1;
    dut_if.card_value = 4'(v);
    @(negedge clk);
    dut_if.card_valid = 1'b0;
    dut_if.card_value = 4'd0;
  endtask

  task automatic press(input gameCommand c, input int hold);
    dut_if.ready   = 1'b1;
    dut_if.command = c;
    repeat (hold) @(negedge clk);
    dut_if.ready   = 1'b0;
    dut_if.command = NONE;
  endtask

  task automatic start();
    dut_if.start_turn = 1'b1;
    @(negedge clk);
    dut_if.start_turn = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " card_req"},      dut_if.card_req, 0);
    chk({tag, " turnIndicator"}, dut_if.turnIndicator, 0);
    chk({tag, " hand_total"},    dut_if.hand_total, 0);
    chk({tag, " soft_hand"},     dut_if.soft_hand, 0);
    chk({tag, " busted"},        dut_if.busted, 0);
    chk({tag, " blackjack"},     dut_if.blackjack, 0);
    chk({tag, " turn_done"},     dut_if.turn_done, 0);
  endtask

  initial begin
    int base;
    int rises;
    logic prev;
    bit steady;

    tbl[0] = '{10, 1, 0,  0, 1'b0, 21, 1'b1, 21, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{ 5, 6, 10, 0, 1'b0, 11, 1'b0, 21, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{ 1, 6, 9,  0, 1'b1, 17, 1'b1, 16, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{10, 6, 10, 0, 1'b0, 16, 1'b0, 26, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{ 1, 1, 9,  0, 1'b0, 12, 1'b1, 21, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{ 2, 3, 4,  5, 1'b1,  5, 1'b0, 14, 1'b0, 1'b0, 1'b0, 1'b1};

    dut_if.start_turn = 1'b0;
    dut_if.ready      = 1'b0;
    dut_if.command    = NONE;
    dut_if.card_valid = 1'b0;
    dut_if.card_value = 4'd0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table of complete turns
    for (int t = 0; t < 6; t++) begin
      ti_seen = 1'b0;
      base = done_cnt;
      start();
      give_card(tbl[t].d0);
      give_card(tbl[t].d1);
      if (tbl[t].exp_ti) begin
        wait_for($sformatf("v%0d turnIndicator", t), 1);
        chk($sformatf("v%0d deal hand_total", t), dut_if.hand_total, tbl[t].deal_total);
        chk($sformatf("v%0d deal soft_hand", t), dut_if.soft_hand, tbl[t].deal_soft);
      end
      if (tbl[t].h0 != 0) begin
        press(HIT, 2);
        give_card(tbl[t].h0);
      end
      if (tbl[t].h1 != 0) begin
        wait_for($sformatf("v%0d turnIndicator2", t), 1);
        press(HIT, 2);
        give_card(tbl[t].h1);
      end
      if (tbl[t].stand) begin
        wait_for($sformatf("v%0d turnIndicator3", t), 1);
        press(STAND, 2);
      end
      wait_done($sformatf("v%0d done", t), base);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d turn_done pulses", t), done_cnt - base, 1);
      chk($sformatf("v%0d hand_total", t), dut_if.hand_total, tbl[t].exp_total);
      chk($sformatf("v%0d soft_hand", t), dut_if.soft_hand, tbl[t].exp_soft);
      chk($sformatf("v%0d busted", t), dut_if.busted, tbl[t].exp_bust);
      chk($sformatf("v%0d blackjack", t), dut_if.blackjack, tbl[t].exp_bj);
      chk($sformatf("v%0d turnIndicator seen", t), ti_seen, tbl[t].exp_ti);
      chk($sformatf("v%0d turnIndicator idle", t), dut_if.turnIndicator, 0);
    end

    // Held HIT key issues exactly one card request
    base = done_cnt;
    start();
    give_card(5);
    give_card(6);
    wait_for("held turnIndicator", 1);
    rises = 0;
    prev = dut_if.card_req;
    dut_if.ready = 1'b1;
    dut_if.command = HIT;
    repeat (20) begin
      @(negedge clk);
      if (dut_if.card_req && !prev) rises++;
      prev = dut_if.card_req;
    end
    dut_if.ready = 1'b0;
    dut_if.command = NONE;
    chk("held card_req rises", rises, 1);
    chk("held turnIndicator low", dut_if.turnIndicator, 0);
    give_card(10);
    wait_done("held done", base);
    chk("held hand_total", dut_if.hand_total, 21);
    chk("held blackjack", dut_if.blackjack, 0);
    chk("held busted", dut_if.busted, 0);

    // STAND after a bust changes nothing
    base = done_cnt;
    start();
    give_card(10);
    give_card(6);
    wait_for("bust turnIndicator", 1);
    press(HIT, 2);
    give_card(10);
    wait_done("bust done", base);
    repeat (2) @(negedge clk);
    base = done_cnt;
    press(STAND, 3);
    repeat (5) @(negedge clk);
    chk("bust stand no done", done_cnt - base, 0);
    chk("bust busted holds", dut_if.busted, 1);
    chk("bust hand_total holds", dut_if.hand_total, 26);
    chk("bust turnIndicator", dut_if.turnIndicator, 0);

    // Deck handshake corners: unsolicited card, slow deck, zero rank, rank 13
    base = done_cnt;
    start();
    give_card(5);
    chk("deck req gap", dut_if.card_req, 0);
    dut_if.card_valid = 1'b1;
    dut_if.card_value = 4'd5;
    @(negedge clk);
    dut_if.card_valid = 1'b0;
    dut_if.card_value = 4'd0;
    steady = 1'b1;
    repeat (7) begin
      @(negedge clk);
      if (dut_if.card_req !== 1'b1) steady = 1'b0;
    end
    chk("deck req steady", steady, 1);
    chk("deck unsolicited ignored", dut_if.hand_total, 5);
    dut_if.card_valid = 1'b1;
    dut_if.card_value = 4'd0;
    @(negedge clk);
    dut_if.card_valid = 1'b0;
    @(negedge clk);
    chk("deck zero req held", dut_if.card_req, 1);
    chk("deck zero ignored", dut_if.hand_total, 5);
    give_card(13);
    wait_for("deck turnIndicator", 1);
    chk("deck clamp total", dut_if.hand_total, 15);
    press(STAND, 2);
    wait_done("deck done", base);
    chk("deck final total", dut_if.hand_total, 15);

    // Reset mid-HIT aborts silently, next turn is clean
    start();
    give_card(2);
    give_card(3);
    wait_for("rst turnIndicator", 1);
    press(HIT, 2);
    chk("rst card_req before", dut_if.card_req, 1);
    base = done_cnt;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midturn reset");
    repeat (3) @(negedge clk);
    chk("rst no done", done_cnt - base, 0);
    reset_n = 1'b1;
    @(negedge clk);
    base = done_cnt;
    start();
    give_card(10);
    give_card(1);
    wait_done("rst next done", base);
    chk("rst next hand_total", dut_if.hand_total, 21);
    chk("rst next blackjack", dut_if.blackjack, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/player_turn_fsm.md
Name: player_turn_fsm

Overview:
- Sequential stage directly downstream of the player button decoder: consumes its ready/command pair and drives its turnIndicator input.
- Runs one player turn: requests the initial two-card deal from the deck stage, accumulates the hand value with soft-ace handling, then serves HIT/STAND requests.
- Ends the turn on STAND, on bust, or automatically at 21, and reports the result to the game controller.

Parameters:
- DEAL_CARDS, 2, number of cards drawn automatically at turn start.
- TARGET, 21, hand value that ends the turn automatically and is the bust threshold.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start_turn  in  1  one-cycle pulse from the game controller; begins a turn when idle.
- ready  in  1  level from the button decoder; high while a command key is held.
- command  in  gameCommand  NONE/HIT/STAND from the button decoder.
- card_valid  in  1  deck stage presents a card.
- card_value  in  4  card rank value: 1 = ace, 2..10 (face cards already mapped to 10).
- card_req  out  1  request for one card from the deck stage.
- turnIndicator  out  1  high while the FSM accepts player commands.
- hand_total  out  5  best hand value, with an ace counted as 11 when that does not exceed TARGET.
- soft_hand  out  1  an ace is currently counted as 11.
- busted  out  1  hand_total > TARGET; sticky until the next start_turn.
- blackjack  out  1  TARGET reached with exactly DEAL_CARDS cards.
- turn_done  out  1  one-cycle pulse when the turn ends.

Behaviour:
- Reset: all outputs 0; state IDLE; hard_sum = 0, ace_seen = 0, card_count = 0. Reset mid-turn aborts immediately, with no turn_done pulse.
- States: IDLE, DEAL, WAIT_CMD, HIT, DONE.
- IDLE:
  - start_turn clears hard_sum, ace_seen, card_count, busted and blackjack, then goes to DEAL.
  - start_turn in any other state is ignored.
- Card handshake:
  - card_req is registered and held high until a cycle with card_req && card_valid; the card is captured in that cycle.
  - card_req drops in the next cycle.
  - card_valid while card_req = 0 is ignored.
  - card_value 0 is ignored (request stays up). Values 11..15 are clamped to 10.
- Accumulation: hard_sum += value; ace_seen |= (value == 1); card_count increments, saturating at 15.
- hand_total = hard_sum + 10 if ace_seen && hard_sum <= 11, else hard_sum. soft_hand = that condition. Both are combinational from registers.
  - Maximum hard_sum is 20 + 10 = 30, so 5 bits suffice.
- DEAL: capture cards until card_count == DEAL_CARDS.
  - If hand_total == TARGET: set blackjack, go to DONE.
  - Otherwise go to WAIT_CMD.
- WAIT_CMD: turnIndicator = 1.
  - A command is accepted only on the rising edge of ready (ready && !ready_q), so a held key issues exactly one command.
  - HIT goes to HIT. STAND goes to DONE. NONE is ignored.
  - A rising edge present on the cycle of entry is accepted only if ready_q was low in the prior cycle; ready_q samples every cycle in all states.
- HIT: turnIndicator = 0; request and capture one card, then evaluate:
  - hard_sum > TARGET: busted = 1, go to DONE.
  - hand_total == TARGET: go to DONE.
  - Otherwise return to WAIT_CMD.
- DONE: turn_done = 1 for exactly one cycle, then IDLE. hand_total, soft_hand, busted and blackjack hold until the next start_turn.
- Player keys are ignored while turnIndicator = 0, including during deal waits.

Decomposition:
- Shared game package:
  - existing gameCommand enum;
  - new turn_state_t enum (IDLE, DEAL, WAIT_CMD, HIT, DONE);
  - constants ACE_BONUS = 10, FACE_VALUE = 10.
- One sub-module, hand_value: purely combinational; hard_sum and ace_seen in, hand_total and soft_hand out. Reused later by the dealer logic.

Test Plan:
- Reset then start_turn; deck supplies 10, 1 → card_req high for two handshakes; hand_total = 21, blackjack = 1, turn_done pulses; turnIndicator never asserted.
- Deal 5, 6 (total 11); hold HIT for 20 cycles → exactly one card_req. Card 10 → hand_total = 21, turn ends without STAND, blackjack = 0.
- Deal 1, 6 (soft 17, soft_hand = 1); HIT, card 9 → hand_total = 16, soft_hand = 0; STAND → turn_done, busted = 0, hand_total holds 16.
- Deal 10, 6; HIT, card 10 → busted = 1, hand_total = 26, turn_done pulses; a later STAND keypress has no effect.
- Deck delays card_valid 7 cycles and pulses card_valid once with card_req low → card_req held steady; the unsolicited card is ignored; card_value 0 is rejected; card_value 13 is counted as 10.
- Assert reset_n low during HIT with card_req high → all outputs 0 immediately; no turn_done pulse; the next start_turn begins a clean turn.
